trip_timer: RTL

Parametrised elapsed-time counter for the trip computer. It generates the half-second and second display pulses and keeps an H:M:S trip clock with saturating second and minute accumulators. It also holds a small first-word-fall-through lap buffer for split-time capture. It sits between the system clock domain and the display and distance blocks. It supersedes the fixed 1024-cycle, 99-hour timer with a configurable prescaler, hour limit and accumulator width, clean rollover, and lap capture.

---
 rtl/trip_timer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/trip_timer.sv
// Trip clock: half-second prescaler, H:M:S time with saturating second/minute
// accumulators, and a first-word-fall-through lap capture buffer.
module trip_timer #(
  parameter int CYCLES_PER_HALF_SEC = 1024,
  parameter int HRS_MAX             = 99,
  parameter int ACCUM_W             = 13,
  parameter int LAP_DEPTH           = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               clear,
  input  logic                               lap_req,
  input  logic                               lap_rd,
  output logic [18:0]                        hms_time,
  output logic [ACCUM_W-1:0]                 sec_accum,
  output logic [ACCUM_W-1:0]                 min_accum,
  output logic                               half_sec_pulse,
  output logic                               sec_pulse,
  output logic                               wrap_pulse,
  output logic [18:0]                        lap_data,
  output logic                               lap_valid,
  output logic                               lap_full,
  output logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count,
  output logic                               lap_overrun
);

  localparam int PSW = (CYCLES_PER_HALF_SEC > 2) ? $clog2(CYCLES_PER_HALF_SEC) : 1;
  localparam int PW  = $clog2(LAP_DEPTH);
  localparam int CW  = $clog2(LAP_DEPTH+1);
  localparam logic [ACCUM_W-1:0] ACC_MAX = {ACCUM_W{1'b1}};

  logic [PSW-1:0] presc;
  logic           phase;
  logic [6:0]     hs;
  logic [5:0]     mins;
  logic [6:0]     hrs;
  logic           ht, adv, hs_wrap, min_wrap, hrs_wrap;

  assign ht       = (presc == PSW'(CYCLES_PER_HALF_SEC-1));
  assign adv      = ht & enable;
  assign hs_wrap  = (hs == 7'd119);
  assign min_wrap = (mins == 6'd59);
  assign hrs_wrap = (hrs == 7'(HRS_MAX));
  assign hms_time = {hrs, mins, hs[6:1]};

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      presc          <= '0;
      phase          <= 1'b0;
      hs             <= '0;
      mins           <= '0;
      hrs            <= '0;
      sec_accum      <= '0;
      min_accum      <= '0;
      half_sec_pulse <= 1'b0;
      sec_pulse      <= 1'b0;
      wrap_pulse     <= 1'b0;
    end else begin
      presc          <= ht ? '0 : presc + 1'b1;
      half_sec_pulse <= ht;
      sec_pulse      <= ht & phase;
      wrap_pulse     <= adv & hs_wrap & min_wrap & hrs_wrap;
      if (ht) phase <= ~phase;
      if (adv) begin
        if (phase && sec_accum != ACC_MAX) sec_accum <= sec_accum + 1'b1;
        if (hs_wrap) begin
          hs <= '0;
          if (min_accum != ACC_MAX) min_accum <= min_accum + 1'b1;
          if (min_wrap) begin
            mins <= '0;
            hrs  <= hrs_wrap ? '0 : hrs + 1'b1;
          end else begin
            mins <= mins + 1'b1;
          end
        end else begin
          hs <= hs + 1'b1;
        end
      end
    end
  end

  // Lap buffer: head, valid, full and count are registered from next-state values.
  logic [LAP_DEPTH-1:0][18:0] mem;
  logic [PW-1:0]              rd_ptr, wr_ptr, rd_nxt;
  logic                       do_pop, do_push;
  logic [CW-1:0]              cnt_nxt;
  logic [18:0]                head_nxt;

  always_comb begin
    rd_nxt   = rd_ptr + 1'b1;
    do_pop   = lap_rd & (lap_count != '0);
    do_push  = lap_req & (~lap_full | do_pop);
    cnt_nxt  = lap_count + CW'(do_push) - CW'(do_pop);
    head_nxt = '0;
    if (cnt_nxt != '0) begin
      if (do_pop)
        head_nxt = (lap_count == CW'(1)) ? hms_time : mem[rd_nxt];
      else
        head_nxt = (lap_count == '0) ? hms_time : lap_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      mem         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      lap_count   <= '0;
      lap_data    <= '0;
      lap_valid   <= 1'b0;
      lap_full    <= 1'b0;
      lap_overrun <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= hms_time;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_nxt;
      lap_count   <= cnt_nxt;
      lap_data    <= head_nxt;
      lap_valid   <= (cnt_nxt != '0);
      lap_full    <= (cnt_nxt == CW'(LAP_DEPTH));
      lap_overrun <= lap_overrun | (lap_req & ~do_push);
    end
  end

endmodule
